// File: rtl/id_ex_hazard_reg_pkg.sv
// Shared types for the ID/EX pipeline register.
//   ctrl_t   : decoded control bundle, MSB to LSB in the order EX expects
//   CTRL_W   : width of ctrl_t
//   CTRL_NOP : all-zero control word used for bubbles
//   fp_reg_match : FP register compare; a double-precision access names an
//                  even/odd pair, so only bits [4:1] are compared
package pipe_pkg;

  localparam int CTRL_W = 25;

  typedef struct packed {
    logic [3:0] AluOp;
    logic [1:0] regDst;
    logic [1:0] memToReg;
    logic [1:0] AluSrc;
    logic       regWrite;
    logic       regwriteF;
    logic       memRead;
    logic       memWrite;
    logic       branch;
    logic       jump;
    logic       pcSrc;
    logic       storeByte;
    logic       bne;
    logic       bfpc;
    logic       sign;
    logic       shift_op;
    logic       float_rs;
    logic       float_rt;
    logic       double;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  function automatic logic fp_reg_match(input logic [4:0] a, input logic [4:0] b,
                                        input logic dbl);
    return dbl ? (a[4:1] == b[4:1]) : (a == b);
  endfunction

endpackage

// File: rtl/id_ex_hazard_reg_if.sv
// Decode-side inputs and EX-side outputs of the ID/EX register.
//   slave  : the pipeline register (consumes id_*/flush, drives ex_*/stall/counters)
//   master : whoever drives the decode stage and observes EX
interface id_ex_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  import pipe_pkg::*;

  logic              id_valid;
  ctrl_t             id_ctrl;
  logic [DATA_W-1:0] id_pc_plus4;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_rd;
  logic [4:0]        id_shamt;
  logic              flush;

  logic              ex_valid;
  ctrl_t             ex_ctrl;
  logic [DATA_W-1:0] ex_pc_plus4;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [4:0]        ex_rs;
  logic [4:0]        ex_rt;
  logic [4:0]        ex_rd;
  logic [4:0]        ex_shamt;
  logic              stall;
  logic [CNT_W-1:0]  bubble_cnt;
  logic [CNT_W-1:0]  load_use_cnt;

  modport slave (
    input  id_valid, id_ctrl, id_pc_plus4, id_rs_data, id_rt_data, id_imm,
           id_rs, id_rt, id_rd, id_shamt, flush,
    output ex_valid, ex_ctrl, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_shamt, stall, bubble_cnt, load_use_cnt
  );

  modport master (
    output id_valid, id_ctrl, id_pc_plus4, id_rs_data, id_rt_data, id_imm,
           id_rs, id_rt, id_rd, id_shamt, flush,
    input  ex_valid, ex_ctrl, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_shamt, stall, bubble_cnt, load_use_cnt
  );

endinterface

// File: rtl/id_ex_hazard_reg_hazard_detect.sv
// Combinational load-use hazard detection.
// Inputs : EX-stage valid/control/rt (the load's destination) and the
//          decode-stage valid/control/rs/rt.
// Output : o_haz, high when the decode instruction reads the register the
//          EX load is about to write, within the same register file.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic       i_ex_valid,
  input  ctrl_t      i_ex_ctrl,
  input  logic [4:0] i_ex_rt,
  input  logic       i_id_valid,
  input  ctrl_t      i_id_ctrl,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  output logic       o_haz
);

  logic w_pre;
  logic w_rt_used;
  logic w_int_hit;
  logic w_fp_hit;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_pre     = i_ex_valid & i_ex_ctrl.memRead & i_id_valid;
    // rt is a source unless it is replaced by the immediate; stores always
    // read rt as the store data.
    w_rt_used = ~i_id_ctrl.AluSrc[0] | i_id_ctrl.memWrite;

    w_int_hit = 1'b0;
    w_fp_hit  = 1'b0;

    if (!i_ex_ctrl.regwriteF) begin
      // Integer $zero never carries a dependency.
      w_int_hit = (i_ex_rt != 5'd0) &&
                  ((!i_id_ctrl.float_rs && (i_id_rs == i_ex_rt)) ||
                   (w_rt_used && !i_id_ctrl.float_rt && (i_id_rt == i_ex_rt)));
    end else begin
      // FP register 0 is an ordinary register.
      w_fp_hit  = (i_id_ctrl.float_rs && fp_reg_match(i_id_rs, i_ex_rt, i_ex_ctrl.double)) ||
                  (w_rt_used && i_id_ctrl.float_rt &&
                   fp_reg_match(i_id_rt, i_ex_rt, i_ex_ctrl.double));
    end

    o_haz = w_pre & (w_int_hit | w_fp_hit);
  end

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard bubble insertion.
// Ports:
//   clk   : pipeline clock
//   reset : synchronous, active-high; clears all EX outputs and counters
//   bus   : id_ex_if slave - decode inputs, flush, EX outputs, stall,
//           saturating bubble / load-use counters
// Update priority per edge: reset > flush > hazard > capture.
module id_ex_hazard_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic clk,
  input  logic reset,
  id_ex_if.slave bus
);

  logic              r_valid;
  ctrl_t             r_ctrl;
  logic [DATA_W-1:0] r_pc_plus4;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [4:0]        r_rs;
  logic [4:0]        r_rt;
  logic [4:0]        r_rd;
  logic [4:0]        r_shamt;
  logic [CNT_W-1:0]  r_bubble_cnt;
  logic [CNT_W-1:0]  r_load_use_cnt;

  logic w_haz;
  logic w_bubble;

  hazard_detect u_hazard_detect (
    .i_ex_valid (r_valid),
    .i_ex_ctrl  (r_ctrl),
    .i_ex_rt    (r_rt),
    .i_id_valid (bus.id_valid),
    .i_id_ctrl  (bus.id_ctrl),
    .i_id_rs    (bus.id_rs),
    .i_id_rt    (bus.id_rt),
    .o_haz      (w_haz)
  );

  // A flush and a hazard produce the same bubble; only the hazard stalls.
  assign w_bubble = bus.flush | w_haz;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid        <= 1'b0;
      r_ctrl         <= CTRL_NOP;
      r_pc_plus4     <= '0;
      r_rs_data      <= '0;
      r_rt_data      <= '0;
      r_imm          <= '0;
      r_rs           <= '0;
      r_rt           <= '0;
      r_rd           <= '0;
      r_shamt        <= '0;
      r_bubble_cnt   <= '0;
      r_load_use_cnt <= '0;
    end else if (w_bubble) begin
      // Datapath fields are held; a zero control word makes them inert.
      r_valid <= 1'b0;
      r_ctrl  <= CTRL_NOP;
      if (r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      if (!bus.flush && r_load_use_cnt != '1)
        r_load_use_cnt <= r_load_use_cnt + CNT_W'(1);
    end else begin
      r_valid    <= bus.id_valid;
      r_ctrl     <= bus.id_valid ? bus.id_ctrl : CTRL_NOP;
      r_pc_plus4 <= bus.id_pc_plus4;
      r_rs_data  <= bus.id_rs_data;
      r_rt_data  <= bus.id_rt_data;
      r_imm      <= bus.id_imm;
      r_rs       <= bus.id_rs;
      r_rt       <= bus.id_rt;
      r_rd       <= bus.id_rd;
      r_shamt    <= bus.id_shamt;
    end
  end

  assign bus.stall        = w_haz & ~bus.flush & ~reset;
  assign bus.ex_valid     = r_valid;
  assign bus.ex_ctrl      = r_ctrl;
  assign bus.ex_pc_plus4  = r_pc_plus4;
  assign bus.ex_rs_data   = r_rs_data;
  assign bus.ex_rt_data   = r_rt_data;
  assign bus.ex_imm       = r_imm;
  assign bus.ex_rs        = r_rs;
  assign bus.ex_rt        = r_rt;
  assign bus.ex_rd        = r_rd;
  assign bus.ex_shamt     = r_shamt;
  assign bus.bubble_cnt   = r_bubble_cnt;
  assign bus.load_use_cnt = r_load_use_cnt;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Scoreboard bench for id_ex_hazard_reg: each directed step drives decode
// inputs just after a rising edge and queues the hand-computed EX state and
// stall for that cycle; a monitor pops and compares on the falling edge.
module tb_id_ex_hazard_reg;
  import pipe_pkg::*;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  typedef struct {
    int                step;
    logic              ev;
    ctrl_t             ctrl;
    logic [DATA_W-1:0] rsd;
    logic [4:0]        rs;
    logic              stall;
    logic [CNT_W-1:0]  bc;
    logic [CNT_W-1:0]  lc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   step_no = 0;
  exp_t sb[$];

  ctrl_t c_add, c_lw, c_addi, c_ldc1, c_fpop;

  id_ex_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  id_ex_hazard_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic ev, input ctrl_t c, input logic [DATA_W-1:0] rsd,
                              input logic [4:0] rs, input logic st,
                              input logic [CNT_W-1:0] bc, input logic [CNT_W-1:0] lc);
    exp_t e;
    e.step = 0; e.ev = ev; e.ctrl = c; e.rsd = rsd; e.rs = rs;
    e.stall = st; e.bc = bc; e.lc = lc;
    return e;
  endfunction

  task automatic drive(input logic rst, input logic fl, input logic v, input ctrl_t c,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [DATA_W-1:0] rsd);
    reset           = rst;
    bus.flush       = fl;
    bus.id_valid    = v;
    bus.id_ctrl     = c;
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_rd       = rt ^ 5'd1;
    bus.id_shamt    = rs;
    bus.id_rs_data  = rsd;
    bus.id_rt_data  = rsd + 32'd1;
    bus.id_imm      = rsd + 32'd2;
    bus.id_pc_plus4 = rsd + 32'd4;
  endtask

  // One directed cycle: drive, then queue the expected observation.
  task automatic step(input logic rst, input logic fl, input logic v, input ctrl_t c,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic [DATA_W-1:0] rsd, input exp_t e);
    @(posedge clk);
    #1;
    drive(rst, fl, v, c, rs, rt, rsd);
    step_no++;
    e.step = step_no;
    sb.push_back(e);
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check($sformatf("s%0d.ex_valid", e.step), 64'(bus.ex_valid), 64'(e.ev));
        check($sformatf("s%0d.ex_ctrl", e.step), 64'(bus.ex_ctrl), 64'(e.ctrl));
        check($sformatf("s%0d.ex_rs_data", e.step), 64'(bus.ex_rs_data), 64'(e.rsd));
        check($sformatf("s%0d.ex_rs", e.step), 64'(bus.ex_rs), 64'(e.rs));
        check($sformatf("s%0d.stall", e.step), 64'(bus.stall), 64'(e.stall));
        check($sformatf("s%0d.bubble_cnt", e.step), 64'(bus.bubble_cnt), 64'(e.bc));
        check($sformatf("s%0d.load_use_cnt", e.step), 64'(bus.load_use_cnt), 64'(e.lc));
      end
    end
  end

  initial begin
    ctrl_t z;
    z = CTRL_NOP;
    c_add  = CTRL_NOP; c_add.regWrite = 1'b1; c_add.regDst = 2'b01; c_add.AluOp = 4'd2;
    c_lw   = CTRL_NOP; c_lw.memRead = 1'b1; c_lw.regWrite = 1'b1;
    c_lw.AluSrc = 2'b01; c_lw.memToReg = 2'b01;
    c_addi = CTRL_NOP; c_addi.regWrite = 1'b1; c_addi.AluSrc = 2'b01; c_addi.AluOp = 4'd2;
    c_ldc1 = CTRL_NOP; c_ldc1.memRead = 1'b1; c_ldc1.regwriteF = 1'b1;
    c_ldc1.double = 1'b1; c_ldc1.AluSrc = 2'b01;
    c_fpop = CTRL_NOP; c_fpop.regwriteF = 1'b1; c_fpop.float_rs = 1'b1;
    c_fpop.float_rt = 1'b1; c_fpop.AluOp = 4'd7;

    drive(1'b1, 1'b0, 1'b0, z, 5'd0, 5'd0, 32'h0);
    repeat (2) @(posedge clk);

    // Reset state, stall low while reset is held.
    step(1, 0, 0, z,      5'd0, 5'd0, 32'h0,    mk(0, z,      32'h0,    5'd0, 0, 16'd0, 16'd0));
    // Plain capture.
    step(0, 0, 1, c_add,  5'd1, 5'd2, 32'h1234, mk(0, z,      32'h0,    5'd0, 0, 16'd0, 16'd0));
    step(0, 0, 1, c_lw,   5'd2, 5'd8, 32'h100,  mk(1, c_add,  32'h1234, 5'd1, 0, 16'd0, 16'd0));
    // Integer load-use: add rs=8 behind lw rt=8.
    step(0, 0, 1, c_add,  5'd8, 5'd9, 32'h55,   mk(1, c_lw,   32'h100,  5'd2, 1, 16'd0, 16'd0));
    step(0, 0, 1, c_add,  5'd8, 5'd9, 32'h55,   mk(0, z,      32'h100,  5'd2, 0, 16'd1, 16'd1));
    step(0, 0, 0, z,      5'd0, 5'd0, 32'h0,    mk(1, c_add,  32'h55,   5'd8, 0, 16'd1, 16'd1));
    // No false hazard on $zero.
    step(0, 0, 1, c_lw,   5'd3, 5'd0, 32'h200,  mk(0, z,      32'h0,    5'd0, 0, 16'd1, 16'd1));
    step(0, 0, 1, c_add,  5'd0, 5'd0, 32'h11,   mk(1, c_lw,   32'h200,  5'd3, 0, 16'd1, 16'd1));
    // No false hazard when rt is replaced by the immediate.
    step(0, 0, 1, c_lw,   5'd4, 5'd8, 32'h300,  mk(1, c_add,  32'h11,   5'd0, 0, 16'd1, 16'd1));
    step(0, 0, 1, c_addi, 5'd3, 5'd8, 32'h22,   mk(1, c_lw,   32'h300,  5'd4, 0, 16'd1, 16'd1));
    // FP double pair: ldc1 f4 vs FP source f5.
    step(0, 0, 1, c_ldc1, 5'd6, 5'd4, 32'h400,  mk(1, c_addi, 32'h22,   5'd3, 0, 16'd1, 16'd1));
    step(0, 0, 1, c_fpop, 5'd5, 5'd10, 32'h33,  mk(1, c_ldc1, 32'h400,  5'd6, 1, 16'd1, 16'd1));
    step(0, 0, 0, z,      5'd0, 5'd0, 32'h0,    mk(0, z,      32'h400,  5'd6, 0, 16'd2, 16'd2));
    // Integer lw r5 vs FP sources f5: different files, no hazard.
    step(0, 0, 1, c_lw,   5'd1, 5'd5, 32'h500,  mk(0, z,      32'h0,    5'd0, 0, 16'd2, 16'd2));
    step(0, 0, 1, c_fpop, 5'd5, 5'd5, 32'h44,   mk(1, c_lw,   32'h500,  5'd1, 0, 16'd2, 16'd2));
    // Flush beats hazard.
    step(0, 0, 1, c_lw,   5'd1, 5'd7, 32'h600,  mk(1, c_fpop, 32'h44,   5'd5, 0, 16'd2, 16'd2));
    step(0, 1, 1, c_add,  5'd7, 5'd0, 32'h66,   mk(1, c_lw,   32'h600,  5'd1, 0, 16'd2, 16'd2));
    step(0, 0, 0, z,      5'd0, 5'd0, 32'h0,    mk(0, z,      32'h600,  5'd1, 0, 16'd3, 16'd2));
    step(0, 0, 0, z,      5'd0, 5'd0, 32'h0,    mk(0, z,      32'h0,    5'd0, 0, 16'd3, 16'd2));
    // Reset asserted while the hazard is present.
    step(0, 0, 1, c_lw,   5'd2, 5'd9, 32'h700,  mk(0, z,      32'h0,    5'd0, 0, 16'd3, 16'd2));
    step(1, 0, 1, c_add,  5'd9, 5'd1, 32'h77,   mk(1, c_lw,   32'h700,  5'd2, 0, 16'd3, 16'd2));
    step(0, 0, 1, c_add,  5'd9, 5'd1, 32'h77,   mk(0, z,      32'h0,    5'd0, 0, 16'd0, 16'd0));
    step(0, 0, 0, z,      5'd0, 5'd0, 32'h0,    mk(1, c_add,  32'h77,   5'd9, 0, 16'd0, 16'd0));

    // Saturation: 2^CNT_W + 3 flushes, unchecked until the end.
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      @(posedge clk);
      #1;
      drive(1'b0, 1'b1, 1'b0, z, 5'd0, 5'd0, 32'h0);
    end
    step(0, 0, 0, z,      5'd0, 5'd0, 32'h0,    mk(0, z,      32'h0,    5'd0, 0, 16'hFFFF, 16'd0));
    step(1, 0, 0, z,      5'd0, 5'd0, 32'h0,    mk(0, z,      32'h0,    5'd0, 0, 16'hFFFF, 16'd0));
    step(0, 0, 0, z,      5'd0, 5'd0, 32'h0,    mk(0, z,      32'h0,    5'd0, 0, 16'd0, 16'd0));

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_hazard_reg.md
Name: id_ex_hazard_reg

Overview:
- ID/EX pipeline register. Captures the decoded control bundle, operands and register fields from the decode stage and presents them to EX.
- Contains load-use hazard detection for the integer and floating-point register files.
- On a hazard it inserts a bubble and asserts stall back to the PC and IF/ID registers.
- Honours a branch/jump flush from EX and keeps saturating performance counters for bubbles and load-use stalls.

Parameters:
- DATA_W, 32, width of operand, immediate and PC datapaths
- CNT_W, 16, width of each saturating performance counter

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  decode stage holds a real instruction
- id_ctrl  in  25  decoded control bundle (ctrl_t)
- id_pc_plus4  in  DATA_W  PC+4 of the decode instruction
- id_rs_data  in  DATA_W  rs/fs operand
- id_rt_data  in  DATA_W  rt/ft operand
- id_imm  in  DATA_W  extended immediate
- id_rs, id_rt, id_rd, id_shamt  in  5 each  register fields
- flush  in  1  EX branch/jump redirect; kills the decode instruction
- ex_valid  out  1  EX instruction is real
- ex_ctrl  out  25  registered control bundle
- ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  registered datapath
- ex_rs, ex_rt, ex_rd, ex_shamt  out  5 each  registered fields
- stall  out  1  hold PC and IF/ID this cycle
- bubble_cnt  out  CNT_W  bubbles inserted (flush or hazard)
- load_use_cnt  out  CNT_W  cycles stalled for load-use

Behaviour:
- Reset, synchronous active-high: every ex_* output, bubble_cnt and load_use_cnt go to 0. stall is 0 while reset is asserted. Reset wins over all other inputs.
- Latency: 1 cycle from id_* to ex_*.
- ctrl_t layout, MSB to LSB: AluOp[3:0], regDst[1:0], memToReg[1:0], AluSrc[1:0], regWrite, regwriteF, memRead, memWrite, branch, jump, pcSrc, storeByte, bne, bfpc, sign, shift_op, float_rs, float_rt, double.
- Combinational hazard term haz, evaluated from the current ex_* outputs against the id_* inputs:
  - Precondition: ex_valid & ex_ctrl.memRead & id_valid.
  - Source use: rs is used always; rt is used when !id_ctrl.AluSrc[0] | id_ctrl.memWrite.
  - Integer match (EX load has ex_ctrl.regwriteF=0): ex_rt != 0, compared against used integer sources only. A source is integer when float_rs=0 for rs, or float_rt=0 for rt. The EX load writes rt.
  - FP match (EX load has ex_ctrl.regwriteF=1): compared against used FP sources only. If ex_ctrl.double=1, compare field[4:1] (even/odd pair); otherwise compare the full 5 bits. Register 0 is not special.
  - An integer load never hazards against an FP source, and an FP load never hazards against an integer source.
- Update priority each clock edge: reset > flush > haz > load.
  - flush: ex_valid<=0 and ex_ctrl<=0. Datapath registers are don't-care (implementation holds them). stall=0. bubble_cnt increments.
  - haz (no flush): same bubble as flush. stall=1. bubble_cnt and load_use_cnt both increment.
  - otherwise: all id_* are captured, with ex_valid<=id_valid. When id_valid=0, ex_ctrl<=0.
- stall = haz & !flush & !reset.
- One-cycle stall sufficiency: after a bubble, ex_ctrl.memRead=0, so haz deasserts the next cycle and the held instruction is captured then.
- Counters saturate at all-ones and never wrap.
- Reset mid-stall clears the registers. The next cycle has no hazard because ex_valid=0.

Decomposition:
- Package pipe_pkg holds:
  - ctrl_t, a packed struct in the field order above
  - CTRL_W=25
  - CTRL_NOP='0
- Sub-module hazard_detect computes haz. It is purely combinational, with inputs ex_valid, ex_ctrl, ex_rt, id_valid, id_ctrl, id_rs, id_rt.
- The registers and counters stay in the top module.

Test Plan:
- Plain capture: lw-free sequence, id_rs_data=0x1234, id_ctrl.regWrite=1 -> next cycle ex_rs_data=0x1234, ex_ctrl.regWrite=1, stall=0, bubble_cnt=0.
- Integer load-use: EX lw (memRead=1, regwriteF=0, ex_rt=8); ID add with rs=8 -> stall=1 for exactly one cycle, ex_valid=0 next cycle, add captured the cycle after, load_use_cnt=1, bubble_cnt=1.
- No false hazard: EX lw rt=0 with ID rs=0 -> stall=0. EX lw rt=8 with ID addi (AluSrc[0]=1) rt=8, rs=3 -> stall=0.
- FP double pair: EX ldc1 (memRead, regwriteF, double, ex_rt=4); ID FP op with float_rs=1, rs=5 -> stall=1. Same case with an integer lw, ex_rt=5, and an FP source 5 -> stall=0.
- Flush beats hazard: hazard condition present with flush=1 -> stall=0, ex_valid=0, bubble_cnt+1, load_use_cnt unchanged.
- Saturation and reset: force 2^CNT_W+3 flushes -> bubble_cnt=0xFFFF. Assert reset during a stall cycle -> all outputs 0 next cycle, stall=0 during reset.
